// File: rtl/mvm_uart_pkg.sv
// rtl/mvm_uart_pkg.sv - shared state encoding and default sizing for the UART MVM system
package mvm_uart_pkg;

  typedef enum logic [1:0] {
    RX_K    = 2'd0,
    RX_X    = 2'd1,
    COMPUTE = 2'd2,
    TX      = 2'd3
  } state_t;

  localparam int DEF_BITS_PER_WORD = 8;
  localparam int DEF_R             = 2;
  localparam int DEF_C             = 2;
  localparam int DEF_W_X           = 4;
  localparam int DEF_W_K           = 4;
  localparam int DEF_W_Y_OUT       = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mvm_uart_ctrl.sv
// rtl/mvm_uart_ctrl.sv - collects K and X from the RX byte stream, requests one MVM, streams Y to TX
module mvm_uart_ctrl
  import mvm_uart_pkg::*;
#(
  parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
  parameter int R             = DEF_R,
  parameter int C             = DEF_C,
  parameter int W_X           = DEF_W_X,
  parameter int W_K           = DEF_W_K,
  parameter int W_Y_OUT       = DEF_W_Y_OUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS_PER_WORD-1:0] rx_data,
  input  logic                     rx_valid,
  output logic [R*C*W_K-1:0]       k_flat,
  output logic [C*W_X-1:0]         x_flat,
  output logic                     mvm_valid,
  input  logic [R*W_Y_OUT-1:0]     y_flat,
  input  logic                     y_valid,
  output logic [BITS_PER_WORD-1:0] tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     rx_drop
);

  localparam int N_K   = R * C;
  localparam int CNT_W = $clog2(max3(N_K, C, R) + 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [W_Y_OUT-1:0] y_mem [R];
  logic [W_Y_OUT-1:0] y_nxt;

  logic last_k, last_x, last_y;
  assign last_k = (cnt == CNT_W'(N_K - 1));
  assign last_x = (cnt == CNT_W'(C - 1));
  assign last_y = (cnt == CNT_W'(R - 1));

  // Decoded from the state register so the drop is flagged in the cycle the byte arrives.
  assign rx_drop = rx_valid && ((state == COMPUTE) || (state == TX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_K;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RX_K:    if (rx_valid && last_k) next_state = RX_X;
      RX_X:    if (rx_valid && last_x) next_state = COMPUTE;
      COMPUTE: if (y_valid)            next_state = TX;
      TX:      if (tx_ready && last_y) next_state = RX_K;
      default:                         next_state = RX_K;
    endcase
  end

  // Element following the one currently on tx_data, preloaded on each accept.
  always_comb begin
    y_nxt = '0;
    for (int i = 1; i < R; i++) begin
      if (cnt == CNT_W'(i - 1)) y_nxt = y_mem[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      k_flat    <= '0;
      x_flat    <= '0;
      mvm_valid <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < R; i++) y_mem[i] <= '0;
    end else begin
      mvm_valid <= 1'b0;
      busy      <= (next_state != RX_K);
      case (state)
        RX_K: if (rx_valid) begin
          for (int i = 0; i < N_K; i++) begin
            if (cnt == CNT_W'(i)) k_flat[i*W_K +: W_K] <= rx_data[W_K-1:0];
          end
          cnt <= last_k ? '0 : cnt + 1'b1;
        end
        RX_X: if (rx_valid) begin
          for (int i = 0; i < C; i++) begin
            if (cnt == CNT_W'(i)) x_flat[i*W_X +: W_X] <= rx_data[W_X-1:0];
          end
          cnt       <= last_x ? '0 : cnt + 1'b1;
          mvm_valid <= last_x;
        end
        COMPUTE: if (y_valid) begin
          for (int i = 0; i < R; i++) y_mem[i] <= y_flat[i*W_Y_OUT +: W_Y_OUT];
          cnt      <= '0;
          tx_valid <= 1'b1;
          tx_data  <= BITS_PER_WORD'($signed(y_flat[W_Y_OUT-1:0]));
        end
        TX: if (tx_ready) begin
          if (last_y) begin
            cnt      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
          end else begin
            cnt     <= cnt + 1'b1;
            tx_data <= BITS_PER_WORD'($signed(y_nxt));
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// tb/tb_mvm_uart_ctrl.sv - randomized self-checking bench with a matrix-level reference model
module tb_mvm_uart_ctrl;

  localparam int BW = 8, R = 2, C = 2, WX = 4, WK = 4, WY = 8;

  logic              clk, rst;
  logic [BW-1:0]     rx_data;
  logic              rx_valid;
  logic [R*C*WK-1:0] k_flat;
  logic [C*WX-1:0]   x_flat;
  logic              mvm_valid;
  logic [R*WY-1:0]   y_flat;
  logic              y_valid;
  logic [BW-1:0]     tx_data;
  logic              tx_valid, tx_ready, busy, rx_drop;

  mvm_uart_ctrl #(
    .BITS_PER_WORD(BW), .R(R), .C(C), .W_X(WX), .W_K(WK), .W_Y_OUT(WY)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .k_flat(k_flat), .x_flat(x_flat), .mvm_valid(mvm_valid),
    .y_flat(y_flat), .y_valid(y_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .rx_drop(rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [7:0] exp_tx[$];
  int accepted = 0, mvm_pulses = 0;
  bit drop_expected = 0, prev_stall = 0;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Y[r] = sum_c K[r][c]*X[c] on signed nibbles, truncated to the 8-bit result width.
  function automatic logic [7:0] model_y(input logic [7:0] kb[4], input logic [7:0] xb[2], input int r);
    int s;
    s = 0;
    for (int c = 0; c < C; c++)
      s += int'($signed(kb[r*C+c][3:0])) * int'($signed(xb[c][3:0]));
    return s[7:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      check("rx_drop", rx_drop, rx_valid && drop_expected);
      if (mvm_valid) mvm_pulses++;
      if (tx_valid && prev_stall) check("tx_hold", tx_data, prev_data);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_extra: got byte %0h expected none", tx_data);
        end else begin
          check("tx_byte", tx_data, exp_tx.pop_front());
        end
        accepted++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] kb[4], input logic [7:0] xb[2],
                           input int mode_drop, input int stall, input bit b2b, input bit rand_ready);
    logic [15:0] kexp, yflat;
    logic [7:0]  xexp;
    logic [7:0]  y[R];
    int start_pulses, target, guard, d;
    for (int i = 0; i < R*C; i++) kexp[i*WK +: WK] = kb[i][3:0];
    for (int i = 0; i < C; i++)   xexp[i*WX +: WX] = xb[i][3:0];
    for (int r = 0; r < R; r++) begin
      y[r] = model_y(kb, xb, r);
      yflat[r*WY +: WY] = y[r];
      exp_tx.push_back(y[r]);
    end
    start_pulses = mvm_pulses;
    check("busy_idle", busy, 0);
    for (int i = 0; i < R*C; i++) send_byte(kb[i], b2b ? 0 : $urandom_range(0, 2));
    for (int i = 0; i < C; i++)   send_byte(xb[i], b2b ? 0 : $urandom_range(0, 2));
    check("mvm_valid_rise", mvm_valid, 1);
    check("k_flat", k_flat, kexp);
    check("x_flat", x_flat, xexp);
    check("busy_compute", busy, 1);
    d = $urandom_range(1, 4);
    for (int j = 0; j < d; j++) begin
      if (mode_drop == 1 && j == 0) begin
        rx_data = 8'hAA; rx_valid = 1'b1; drop_expected = 1;
      end
      step();
      rx_valid = 1'b0; drop_expected = 0;
      if (j == 0) check("mvm_valid_fall", mvm_valid, 0);
    end
    y_flat = yflat; y_valid = 1'b1;
    if (mode_drop == 2) begin
      rx_data = 8'hAA; rx_valid = 1'b1; drop_expected = 1;
    end
    step();
    y_valid = 1'b0; rx_valid = 1'b0; drop_expected = 0; y_flat = 16'($urandom);
    check("tx_valid_rise", tx_valid, 1);
    check("tx_first", tx_data, y[0]);
    check("busy_tx", busy, 1);
    check("k_hold", k_flat, kexp);
    check("x_hold", x_flat, xexp);
    check("mvm_once", mvm_pulses - start_pulses, 1);
    target = accepted + R;
    guard = 0;
    if (b2b) begin
      tx_ready = 1'b1;
      step();
      rx_data = 8'h5A; rx_valid = 1'b1; drop_expected = 1;
      step();
      rx_valid = 1'b0; drop_expected = 0;
    end else begin
      while (accepted < target && guard < 300) begin
        if (guard < stall) begin
          check("stall_valid", tx_valid, 1);
          check("stall_data", tx_data, y[0]);
        end
        tx_ready = (guard < stall) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        step();
        guard++;
      end
    end
    if (accepted != target) begin
      checks++; errors++;
      $display("FAIL tx_count: got %0d accepts expected %0d", accepted, target);
    end
    check("tx_valid_fall", tx_valid, 0);
    check("busy_done", busy, 0);
    check("tx_queue_empty", exp_tx.size(), 0);
    if (!b2b) tx_ready = 1'b0;
  endtask

  task automatic rand_frame(output logic [7:0] kb[4], output logic [7:0] xb[2]);
    for (int i = 0; i < 4; i++) kb[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) xb[i] = 8'($urandom);
  endtask

  logic [7:0] kb[4];
  logic [7:0] xb[2];

  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 0; y_flat = '0; y_valid = 0; tx_ready = 0;
    #2;
    check("rst_k", k_flat, 0);
    check("rst_tx", {tx_valid, tx_data, mvm_valid, busy, rx_drop}, 0);
    step(); step();
    rst = 1'b0;
    step();

    kb = '{8'h01, 8'h02, 8'h03, 8'h04}; xb = '{8'h05, 8'h06};
    check("model_pos0", model_y(kb, xb, 0), 8'h11);
    check("model_pos1", model_y(kb, xb, 1), 8'h27);
    run_frame(kb, xb, 0, 0, 0, 0);
    check("pos_k_lit", k_flat, 16'h4321);
    check("pos_x_lit", x_flat, 8'h65);

    kb = '{8'h0F, 8'h00, 8'h00, 8'h0E}; xb = '{8'h03, 8'h07};
    check("model_sgn0", model_y(kb, xb, 0), 8'hFD);
    check("model_sgn1", model_y(kb, xb, 1), 8'hF2);
    run_frame(kb, xb, 0, 0, 0, 0);
    check("sgn_k_lit", k_flat, 16'hE00F);
    check("sgn_x_lit", x_flat, 8'h73);

    kb = '{8'h01, 8'h02, 8'h03, 8'h04}; xb = '{8'h05, 8'h06};
    run_frame(kb, xb, 0, 10, 0, 0);
    kb = '{8'hF7, 8'h35, 8'h8C, 8'h21}; xb = '{8'hB9, 8'h4E};
    run_frame(kb, xb, 1, 0, 0, 1);
    run_frame(kb, xb, 2, 3, 0, 1);

    y_flat = 16'hFFFF; y_valid = 1'b1; tx_ready = 1'b1;
    step();
    y_valid = 1'b0;
    check("ign_y_txv", tx_valid, 0);
    check("ign_y_busy", busy, 0);
    tx_ready = 1'b0;

    kb = '{8'h09, 8'h0A, 8'h0B, 8'h0C};
    for (int i = 0; i < 3; i++) send_byte(kb[i], 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_k", k_flat, 0);
    check("rst_mid_x", x_flat, 0);
    check("rst_mid_out", {tx_valid, tx_data, mvm_valid, busy, rx_drop}, 0);
    step();
    rst = 1'b0;
    step();
    rand_frame(kb, xb);
    run_frame(kb, xb, 0, 0, 0, 0);

    tx_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_frame(kb, xb);
      run_frame(kb, xb, 0, 0, 1, 0);
    end
    tx_ready = 1'b0;

    for (int f = 0; f < 20; f++) begin
      rand_frame(kb, xb);
      run_frame(kb, xb, $urandom_range(0, 2), $urandom_range(0, 4), 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
